// File: rtl/csr_metric_dumper.sv
// csr_metric_dumper: snapshots NUM_CSRS performance counters from the CSR file
// and streams them as a framed, XOR-checksummed byte sequence over valid/ready.
// Frame: 0xA5, then per counter {index, b3, b2, b1, b0}, then checksum.
// Optional feature macro: CSR_DUMP_CLEAR_EN (clear each counter through the
// CSR write port in the cycle it is sampled). Default build ties the write
// port to zero.
//
// Stream handshake: a byte moves on a rising clk edge where outValid && outReady.
// outValid/outData are registered, never depend combinationally on outReady,
// and hold stable while outValid && !outReady.

module csr_metric_dumper #(
    parameter int NUM_CSRS      = 4,
    parameter int PERIOD_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        dumpReq,
    input  logic [31:0] csr,
    output logic [3:0]  readAddr,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        busy,
    output logic [15:0] frameCount,
    output logic        csrWEn,
    output logic [11:0] csrWAddr,
    output logic [31:0] csrWData,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_IDX    = 4'(NUM_CSRS - 1);
    localparam logic [4:0]  NUM_C5      = 5'(NUM_CSRS);
    localparam logic [31:0] PERIOD_LAST = (PERIOD_CYCLES > 0) ? 32'(PERIOD_CYCLES - 1) : 32'd0;
    localparam logic [7:0]  HEADER      = 8'hA5;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  read_addr_q, read_addr_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]  ctr_q, ctr_d;      // counter whose bytes are being loaded next
    logic [2:0]  fld_q, fld_d;      // 0 = index byte, 1..4 = counter bytes MSB first
    logic [7:0]  csum_q, csum_d;
    logic        last_q, last_d;    // checksum byte currently presented
    // Snapshot is a shift chain: capture shifts counters in at the top, send
    // consumes word 0 and shifts down, so no variable indexing is needed.
    logic [31:0] snap_q [NUM_CSRS];
    logic [31:0] snap_d [NUM_CSRS];

    logic        timer_hit;
    logic [7:0]  data_byte;

    // Period timer: free-running, wraps at PERIOD_CYCLES-1 and raises a request.
    always_comb begin
        timer_hit = 1'b0;
        timer_d   = 32'd0;
        if (PERIOD_CYCLES != 0) begin
            timer_hit = (timer_q == PERIOD_LAST);
            timer_d   = timer_hit ? 32'd0 : timer_q + 32'd1;
        end
    end

    // Next data byte of the current counter record.
    always_comb begin
        data_byte = 8'h00;
        case (fld_q)
            3'd0:    data_byte = {4'b0, ctr_q[3:0]};
            3'd1:    data_byte = snap_q[0][31:24];
            3'd2:    data_byte = snap_q[0][23:16];
            3'd3:    data_byte = snap_q[0][15:8];
            default: data_byte = snap_q[0][7:0];
        endcase
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | dumpReq | timer_hit;
        idx_d       = idx_q;
        read_addr_d = read_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        ctr_d       = ctr_q;
        fld_d       = fld_q;
        csum_d      = csum_q;
        last_d      = last_q;
        snap_d      = snap_q;

        case (state_q)
            S_IDLE: begin
                // Requests arriving in the consuming cycle fold into this frame.
                if (pending_q) begin
                    pending_d   = 1'b0;
                    busy_d      = 1'b1;
                    read_addr_d = 4'd0;
                    idx_d       = 4'd0;
                    state_d     = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                for (int k = 0; k < NUM_CSRS - 1; k++) begin
                    snap_d[k] = snap_q[k+1];
                end
                snap_d[NUM_CSRS-1] = csr;
                if (idx_q == LAST_IDX) begin
                    read_addr_d = 4'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER;
                    ctr_d       = 5'd0;
                    fld_d       = 3'd0;
                    csum_d      = 8'h00;
                    last_d      = 1'b0;
                    state_d     = S_SEND;
                end else begin
                    read_addr_d = idx_q + 4'd1;
                    idx_d       = idx_q + 4'd1;
                end
            end
            S_SEND: begin
                if (out_valid_q && outReady) begin
                    if (last_q) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        last_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else if (ctr_q == NUM_C5) begin
                        out_data_d = csum_q;
                        last_d     = 1'b1;
                    end else begin
                        out_data_d = data_byte;
                        csum_d     = csum_q ^ data_byte;
                        if (fld_q == 3'd4) begin
                            fld_d = 3'd0;
                            ctr_d = ctr_q + 5'd1;
                            for (int k = 0; k < NUM_CSRS - 1; k++) begin
                                snap_d[k] = snap_q[k+1];
                            end
                        end else begin
                            fld_d = fld_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            timer_q     <= 32'd0;
            idx_q       <= 4'd0;
            read_addr_q <= 4'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            ctr_q       <= 5'd0;
            fld_q       <= 3'd0;
            csum_q      <= 8'h00;
            last_q      <= 1'b0;
            for (int k = 0; k < NUM_CSRS; k++) begin
                snap_q[k] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            read_addr_q <= read_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            ctr_q       <= ctr_d;
            fld_q       <= fld_d;
            csum_q      <= csum_d;
            last_q      <= last_d;
            snap_q      <= snap_d;
        end
    end

    assign readAddr   = read_addr_q;
    assign outData    = out_data_q;
    assign outValid   = out_valid_q;
    assign busy       = busy_q;
    assign frameCount = frame_cnt_q;
    assign dbgState   = state_q;

`ifdef CSR_DUMP_CLEAR_EN
    // Clear each counter in the same cycle its value is captured.
    assign csrWEn   = (state_q == S_CAPTURE);
    assign csrWAddr = (state_q == S_CAPTURE) ? {8'b0, idx_q} : 12'd0;
    assign csrWData = 32'd0;
`else
    assign csrWEn   = 1'b0;
    assign csrWAddr = 12'd0;
    assign csrWData = 32'd0;
`endif

endmodule
